// File: rtl/ws2812_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_frame_tx
//  Description : Serialises a flattened 8x8 life frame (64 cells) onto a
//                WS2812B single-wire NRZ data line. Each cell is sent as a
//                24-bit GRB colour word, MSB first, then the line is held low
//                for the latch gap and a one-cycle frame_done pulse is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_frame_tx #(
    parameter int          BIT_CYCLES   = 15,
    parameter int          T0H_CYCLES   = 4,
    parameter int          T1H_CYCLES   = 8,
    parameter int          LATCH_CYCLES = 900,
    parameter logic [23:0] ALIVE_GRB    = 24'h001000,
    parameter logic [23:0] DEAD_GRB     = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic        ws_dout,
    output logic        busy,
    output logic        frame_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(BIT_CYCLES);
    localparam int c_LAT_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_BIT_LAST   = c_CNT_W'(BIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_T0H        = c_CNT_W'(T0H_CYCLES);
    localparam logic [c_CNT_W-1:0] c_T1H        = c_CNT_W'(T1H_CYCLES);
    localparam logic [c_LAT_W-1:0] c_LATCH_LAST = c_LAT_W'(LATCH_CYCLES - 1);

    localparam logic [5:0] c_PIX_LAST = 6'd63;
    localparam logic [4:0] c_BIT_MSB  = 5'd23;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SEND  = 2'd1;
    localparam logic [1:0] c_ST_LATCH = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [63:0]        r_shadow;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_LAT_W-1:0] r_lcnt;
    logic [5:0]         r_pix;
    logic [4:0]         r_bit;
    logic               r_dout;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [1:0]         w_state_nxt;
    logic               w_bit_end;
    logic               w_last_bit;
    logic               w_latch_end;
    logic [63:0]        w_shadow_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_LAT_W-1:0] w_lcnt_nxt;
    logic [5:0]         w_pix_nxt;
    logic [4:0]         w_bit_nxt;
    logic [23:0]        w_grb_nxt;
    logic [c_CNT_W-1:0] w_thi_nxt;
    logic               w_dout_nxt;

    assign w_bit_end   = (r_cnt == c_BIT_LAST);
    assign w_last_bit  = w_bit_end && (r_pix == c_PIX_LAST) && (r_bit == 5'd0);
    assign w_latch_end = (r_state == c_ST_LATCH) && (r_lcnt == c_LATCH_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decision: accept in IDLE, leave SEND after the very last bit,
    // leave LATCH once the gap has fully elapsed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (frame_valid) begin
                    w_state_nxt = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                if (w_last_bit) begin
                    w_state_nxt = c_ST_LATCH;
                end
            end
            c_ST_LATCH: begin
                if (w_latch_end) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Next values of the bit timer, bit/pixel position and latch timer; the
    // data line for the coming cycle is derived from these so it can be
    // registered and still show the first high cycle right after acceptance
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_cnt_nxt    = r_cnt;
        w_lcnt_nxt   = '0;
        w_pix_nxt    = r_pix;
        w_bit_nxt    = r_bit;
        case (r_state)
            c_ST_IDLE: begin
                if (frame_valid) begin
                    w_shadow_nxt = frame_in;
                    w_cnt_nxt    = '0;
                    w_pix_nxt    = 6'd0;
                    w_bit_nxt    = c_BIT_MSB;
                end
            end
            c_ST_SEND: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit == 5'd0) begin
                        // pixel 63 wraps to 0 here, harmless since LATCH follows
                        w_bit_nxt = c_BIT_MSB;
                        w_pix_nxt = r_pix + 6'd1;
                    end else begin
                        w_bit_nxt = r_bit - 5'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_LATCH: begin
                if (!w_latch_end) begin
                    w_lcnt_nxt = r_lcnt + 1'b1;
                end
            end
            default: begin
                w_lcnt_nxt = '0;
            end
        endcase

        // Cell at pixel p lives at bit 63-p, which for a 6-bit p is simply ~p
        w_grb_nxt  = w_shadow_nxt[~w_pix_nxt] ? ALIVE_GRB : DEAD_GRB;
        w_thi_nxt  = w_grb_nxt[w_bit_nxt] ? c_T1H : c_T0H;
        w_dout_nxt = (w_state_nxt == c_ST_SEND) && (w_cnt_nxt < w_thi_nxt);
    end

    // Datapath registers, including the flop that drives the data line
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            r_lcnt   <= '0;
            r_pix    <= '0;
            r_bit    <= '0;
            r_dout   <= 1'b0;
        end else begin
            r_shadow <= w_shadow_nxt;
            r_cnt    <= w_cnt_nxt;
            r_lcnt   <= w_lcnt_nxt;
            r_pix    <= w_pix_nxt;
            r_bit    <= w_bit_nxt;
            r_dout   <= w_dout_nxt;
        end
    end

    // Status outputs decoded from the current state
    always_comb begin
        frame_ready = (r_state == c_ST_IDLE);
        busy        = (r_state != c_ST_IDLE);
        frame_done  = w_latch_end;
    end

    assign ws_dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_frame_tx
//  Description : Self-checking bench for ws2812_frame_tx. A cycle-indexed
//                model computes the expected line waveform and status from
//                the cycle count since acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_frame_tx;

    localparam int          BC    = 6;
    localparam int          T0H   = 2;
    localparam int          T1H   = 4;
    localparam int          LAT   = 10;
    localparam logic [23:0] ALIVE = 24'hFFFFFF;
    localparam logic [23:0] DEAD  = 24'h000000;
    localparam int          NBITS = 64 * 24;
    localparam int          TOTAL = NBITS * BC + LAT;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic        ws_dout;
    logic        busy;
    logic        frame_done;

    ws2812_frame_tx #(
        .BIT_CYCLES   (BC),
        .T0H_CYCLES   (T0H),
        .T1H_CYCLES   (T1H),
        .LATCH_CYCLES (LAT),
        .ALIVE_GRB    (ALIVE),
        .DEAD_GRB     (DEAD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .ws_dout     (ws_dout),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // model state: m_t = cycles since acceptance (0 = idle)
    int          m_t = 0;
    bit          m_known = 1'b0;
    logic [63:0] m_frame = '0;
    int          m_acc = 0;
    int          m_done = 0;
    int          m_exp_high = -1;
    int          next_exp_high = -1;

    // observations of the DUT over the current frame
    int   d_high = 0;
    int   d_rise = 0;
    int   d_busy = 0;
    logic d_prev = 1'b0;

    logic [3:0] exp_v;
    logic [3:0] act_v;

    // {ws_dout, frame_ready, busy, frame_done} expected t cycles after acceptance
    function automatic logic [3:0] expect_out(input int t, input logic [63:0] f);
        int k, bn, pos, pix, b, hi;
        logic [23:0] col;
        if (t == 0) return 4'b0100;
        if (t <= NBITS * BC) begin
            k   = t - 1;
            bn  = k / BC;
            pos = k % BC;
            pix = bn / 24;
            b   = 23 - (bn % 24);
            col = f[63 - pix] ? ALIVE : DEAD;
            hi  = col[b] ? T1H : T0H;
            return {(pos < hi), 3'b010};
        end
        return {1'b0, 1'b0, 1'b1, (t == TOTAL)};
    endfunction

    // compare DUT against the model every cycle, then advance the model
    always @(negedge clk) begin
        if (m_known) begin
            exp_v = expect_out(m_t, m_frame);
            act_v = {ws_dout, frame_ready, busy, frame_done};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL cycle t=%0d {dout,ready,busy,done} got %b want %b", m_t, act_v, exp_v);
            end
            if (busy === 1'b1) d_busy++;
            if (ws_dout === 1'b1) d_high++;
            if (ws_dout === 1'b1 && d_prev !== 1'b1) d_rise++;
            d_prev = ws_dout;
            if (frame_done === 1'b1) begin
                tests++;
                if (d_busy != 9226) begin
                    fails++;
                    $display("FAIL busy_len got %0d want 9226", d_busy);
                end
                tests++;
                if (d_rise != 1536) begin
                    fails++;
                    $display("FAIL pulse_count got %0d want 1536", d_rise);
                end
                if (m_exp_high >= 0) begin
                    tests++;
                    if (d_high != m_exp_high) begin
                        fails++;
                        $display("FAIL high_cycles got %0d want %0d", d_high, m_exp_high);
                    end
                end
            end
        end
        if (reset) begin
            m_known = 1'b1;
            m_t     = 0;
        end else if (m_known) begin
            if (m_t == 0) begin
                if (frame_valid) begin
                    m_t        = 1;
                    m_frame    = frame_in;
                    m_acc++;
                    m_exp_high = next_exp_high;
                    d_busy     = 0;
                    d_high     = 0;
                    d_rise     = 0;
                    d_prev     = 1'b0;
                end
            end else if (m_t == TOTAL) begin
                m_t = 0;
                m_done++;
            end else begin
                m_t++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // present a frame and wait (bounded) until it is accepted
    task automatic offer(input logic [63:0] f, input int eh, input int maxc);
        int a0;
        a0            = m_acc;
        frame_in      = f;
        next_exp_high = eh;
        frame_valid   = 1'b1;
        for (int i = 0; i < maxc && m_acc == a0; i++) tick();
        tests++;
        if (m_acc == a0) begin
            fails++;
            $display("FAIL accept_timeout got acc=%0d want %0d", m_acc, a0 + 1);
        end
    endtask

    // wait (bounded) for the end of the current frame
    task automatic wait_done();
        int d0;
        d0 = m_done;
        for (int i = 0; i < TOTAL + 20 && m_done == d0; i++) tick();
        tests++;
        if (m_done == d0) begin
            fails++;
            $display("FAIL done_timeout got done=%0d want %0d", m_done, d0 + 1);
        end
    endtask

    // random frame_valid/frame_in activity while a frame is in flight
    task automatic jitter(input int n);
        for (int i = 0; i < n; i++) begin
            frame_valid = 1'($urandom_range(0, 1));
            frame_in    = {$urandom, $urandom};
            tick();
        end
        frame_valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        frame_valid = 1'b1;
        frame_in    = 64'h0;
        repeat (3) tick();
        reset = 1'b0;

        // all-dead frame, accepted on the first edge after reset
        offer(64'h0, 3072, 20);
        frame_valid = 1'b0;
        wait_done();

        // single first cell; frame_in cleared after acceptance
        offer(64'h8000_0000_0000_0000, 3120, 20);
        frame_in    = 64'h0;
        frame_valid = 1'b0;
        wait_done();

        // last cell only
        offer(64'h1, 3120, 20);
        frame_valid = 1'b0;
        wait_done();

        // back-to-back with frame_valid held high
        offer(64'h0, 3072, 20);
        offer(64'h8000_0000_0000_0000, 3120, TOTAL + 20);
        jitter(2000);
        wait_done();

        // random frame with random mid-frame activity
        offer({$urandom, $urandom}, -1, 20);
        jitter(3000);
        wait_done();

        // reset during bit 700
        offer({$urandom, $urandom}, -1, 20);
        frame_valid = 1'b0;
        for (int i = 0; i < TOTAL && m_t != 700 * BC + 1; i++) tick();
        tests++;
        if (m_t != 700 * BC + 1) begin
            fails++;
            $display("FAIL reach_bit700 got t=%0d want %0d", m_t, 700 * BC + 1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // fresh frame after the abort
        offer(64'h8000_0000_0000_0000, 3120, 20);
        frame_valid = 1'b0;
        wait_done();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
